// File: rtl/dec_pkg.sv
// Shared types and constants for the 256-line decoder select path.
// Consumers: dec_index_sequencer (optional DEC_SEQ_STRIDE_EN stride support).
package dec_pkg;

    localparam int IDX_W     = 8;
    localparam int NUM_LINES = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_t;

endpackage : dec_pkg

// File: rtl/dec_index_sequencer.sv
// Command-driven generator of select codes for the one-hot decoder stage.
// Emits a single index or a (wrapping) range scan on a valid/ready stream.
// Build option: DEC_SEQ_STRIDE_EN adds the cmd_stride port and a stride register;
// without it the scan step is fixed at 1.
module dec_index_sequencer
    import dec_pkg::*;
#(
    parameter int IDX_W = dec_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [IDX_W-1:0] cmd_start,
    input  logic [IDX_W-1:0] cmd_end,
`ifdef DEC_SEQ_STRIDE_EN
    input  logic [IDX_W-1:0] cmd_stride,
`endif
    input  logic             abort,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             busy,
    output logic             done
);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] rem_q,   rem_d;
    logic             last_q,  last_d;
    logic             done_q,  done_d;

    logic [IDX_W-1:0] step_cur;   // stride of the command in progress
    logic [IDX_W-1:0] step_new;   // stride of the command being accepted

`ifdef DEC_SEQ_STRIDE_EN
    logic [IDX_W-1:0] stride_q, stride_d;

    // Zero stride is promoted to 1 so a scan always advances.
    always_comb begin
        step_new = (cmd_stride == '0) ? IDX_W'(1) : cmd_stride;
        step_cur = stride_q;
    end
`else
    // Fixed unit step when the stride option is not built.
    always_comb begin
        step_new = IDX_W'(1);
        step_cur = IDX_W'(1);
    end
`endif

    // Next-state logic: accept, step, finish, abort.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef DEC_SEQ_STRIDE_EN
        stride_d = stride_q;
`endif
        if (abort) begin
            // Any in-flight handshake this cycle is the final one; no done.
            state_d = IDLE;
            last_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (cmd_valid) begin
                state_d = EMIT;
                idx_d   = cmd_start;
                rem_d   = cmd_mode ? (cmd_end - cmd_start) : '0;
`ifdef DEC_SEQ_STRIDE_EN
                stride_d = step_new;
                last_d   = (rem_d < step_new);
`else
                last_d   = (rem_d == '0);
`endif
            end
        end else if (idx_ready) begin
            if (last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                last_d  = 1'b0;
            end else begin
                idx_d = idx_q + step_cur;
                rem_d = rem_q - step_cur;
`ifdef DEC_SEQ_STRIDE_EN
                last_d = (rem_d < step_cur);
`else
                last_d = (rem_d == '0);
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEC_SEQ_STRIDE_EN
            stride_q <= IDX_W'(1);
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef DEC_SEQ_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    // step_new is only consumed by the stride build; keep it referenced otherwise.
    logic unused_step;
    always_comb unused_step = ^step_new;

    assign cmd_ready = (state_q == IDLE) & rst_n & ~abort;
    assign idx_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign idx       = idx_q;
    assign idx_last  = last_q;
    assign done      = done_q;

endmodule : dec_index_sequencer

// File: tb/tb_dec_index_sequencer.sv
// Self-checking bench for dec_index_sequencer: directed scenarios followed by
// randomized commands, checked against a queue-based model of emitted indices.
module tb_dec_index_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_mode;
    logic [W-1:0] cmd_start;
    logic [W-1:0] cmd_end;
    logic [W-1:0] cmd_stride;
    logic         abort;
    logic         idx_valid;
    logic         idx_ready;
    logic [W-1:0] idx;
    logic         idx_last;
    logic         busy;
    logic         done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: pending indices of the command in progress.
    int  exp_q[$];
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;
    bit  m_rst  = 1'b0;

    always #5 clk = ~clk;

    dec_index_sequencer #(.IDX_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
`ifdef DEC_SEQ_STRIDE_EN
        .cmd_stride (cmd_stride),
`endif
        .abort      (abort),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .idx_last   (idx_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected index list: floor(d/s)+1 beats starting at start, stepping mod 256.
    task automatic load_cmd(input bit mode, input int st, input int en, input int sr);
        int d, s, n;
        s = 1;
`ifdef DEC_SEQ_STRIDE_EN
        s = (sr == 0) ? 1 : sr;
`endif
        d = mode ? ((en - st) & 255) : 0;
        n = d / s + 1;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back((st + k * s) & 255);
    endtask

    // One clock cycle: drive inputs, check cmd_ready, advance model, check outputs.
    task automatic cycle(input bit rn, input bit v, input bit mode, input int st, input int en,
                         input int sr, input bit ab, input bit rdy);
        rst_n      = rn;
        cmd_valid  = v;
        cmd_mode   = mode;
        cmd_start  = W'(st);
        cmd_end    = W'(en);
        cmd_stride = W'(sr);
        abort      = ab;
        idx_ready  = rdy;
        #1;
        check("cmd_ready", cmd_ready, !m_busy && rn && !ab);
        m_done = 1'b0;
        m_rst  = 1'b0;
        if (!rn) begin
            m_busy = 1'b0; exp_q.delete(); m_rst = 1'b1;
        end else if (ab) begin
            m_busy = 1'b0; exp_q.delete();
        end else if (m_busy) begin
            if (rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end else if (v) begin
            load_cmd(mode, st, en, sr);
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        check("idx_valid", idx_valid, m_busy);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        if (m_busy) begin
            check("idx", idx, exp_q[0]);
            check("idx_last", idx_last, exp_q.size() == 1);
        end else begin
            check("idx_last_idle", idx_last, 0);
        end
        if (m_rst) check("idx_reset", idx, 0);
    endtask

    task automatic idle_cycle(input bit rdy);
        cycle(1, 0, 0, 0, 0, 1, 0, rdy);
    endtask

    initial begin
        int budget;
        // Reset
        cycle(0, 1, 1, 8'h33, 8'h40, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycle(1);

        // Single index 0x2A
        cycle(1, 1, 0, 8'h2A, 8'h77, 1, 0, 1);
        check("single_idx", idx, 8'h2A);
        check("single_last", idx_last, 1);
        idle_cycle(1);
        idle_cycle(1);

        // Scan 0x10..0x13, then back-to-back wrap scan 0xFE..0x01
        cycle(1, 1, 1, 8'h10, 8'h13, 1, 0, 1);
        repeat (3) idle_cycle(1);
        cycle(1, 1, 1, 8'hFE, 8'h01, 1, 0, 1);   // final beat of first scan; second held off
        cycle(1, 1, 1, 8'hFE, 8'h01, 1, 0, 1);   // accepted the cycle done pulses
        check("b2b_first", idx, 8'hFE);
        repeat (4) idle_cycle(1);

`ifdef DEC_SEQ_STRIDE_EN
        // Stride 3 wrap: 0xFE, 0x01, 0x04
        cycle(1, 1, 1, 8'hFE, 8'h05, 3, 0, 1);
        repeat (3) idle_cycle(1);
        // Stride 0 behaves as 1
        cycle(1, 1, 1, 8'h20, 8'h22, 0, 0, 1);
        repeat (3) idle_cycle(1);
`endif

        // Backpressure during 0x10..0x13
        cycle(1, 1, 1, 8'h10, 8'h13, 1, 0, 1);
        for (int k = 0; k < 12; k++) idle_cycle(k % 4 == 0 || k % 4 == 3);
        idle_cycle(1);

        // Abort on the 3rd beat (handshake counted, nothing more)
        cycle(1, 1, 1, 8'h10, 8'h13, 1, 0, 1);
        idle_cycle(1);
        idle_cycle(1);
        cycle(1, 0, 0, 0, 0, 1, 1, 1);
        idle_cycle(1);
        // Abort blocks acceptance in IDLE
        cycle(1, 1, 0, 8'h55, 8'h55, 1, 1, 1);
        idle_cycle(1);

        // Reset mid-scan
        cycle(1, 1, 1, 8'h80, 8'h90, 1, 0, 1);
        idle_cycle(1);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        idle_cycle(1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int st;
            st = int'($urandom_range(0, 255));
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) != 0),
                  st,
                  (st + int'($urandom_range(0, 14))) & 255,
                  int'($urandom_range(0, 5)),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) < 7));
        end

        // Drain with a bounded wait
        budget = 0;
        while (m_busy && budget < 300) begin
            idle_cycle(1);
            budget++;
        end
        if (m_busy) check("drain_timeout", 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dec_index_sequencer
